// File: rtl/ram_sdp_clear.sv
// Single-clock simple-dual-port RAM with byte strobes, selectable read-during-write
// policy, optional output register and a one-word-per-cycle hardware clear engine.
module ram_sdp_clear #(
  parameter int unsigned                DATA_WIDTH     = 32,
  parameter int unsigned                ADDR_BITS      = 8,
  parameter string                      INIT_FILE      = "",
  parameter logic [DATA_WIDTH-1:0]      CLEAR_VALUE    = '0,
  parameter bit                         CLEAR_ON_RESET = 1'b1,
  parameter int unsigned                OUTPUT_REG     = 0,
  parameter bit                         BYPASS         = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  output logic                    busy_o,
  input  logic                    write_enable_i,
  input  logic [ADDR_BITS-1:0]    write_addr_i,
  input  logic [DATA_WIDTH-1:0]   write_data_i,
  input  logic [DATA_WIDTH/8-1:0] write_strb_i,
  input  logic                    read_enable_i,
  input  logic [ADDR_BITS-1:0]    read_addr_i,
  output logic [DATA_WIDTH-1:0]   read_data_o,
  output logic                    read_valid_o
);

  localparam int DEPTH  = 2 ** ADDR_BITS;
  localparam int STRB_W = DATA_WIDTH / 8;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("ram_sdp_clear: DATA_WIDTH must be a multiple of 8");
  end
  if (OUTPUT_REG > 1) begin : g_bad_output_reg
    $error("ram_sdp_clear: OUTPUT_REG must be 0 or 1");
  end

  typedef enum logic {
    IDLE,
    CLEARING
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;

  logic                  clear_we;
  logic                  user_we;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign busy_o = (state_q == CLEARING);

  // The engine and user writes share the single write port; reset blocks both.
  assign clear_we  = busy_o && !reset_i;
  assign user_we   = write_enable_i && (state_q == IDLE) && !clear_i && !reset_i;
  assign rd_accept = read_enable_i && !busy_o;

  // ---------------------------------------------------------------------------
  // Clear engine FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= CLEAR_ON_RESET ? CLEARING : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end
      end
      CLEARING: begin
        if (clear_i) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch so it maps onto block RAM; wiping it is
  // the clear engine's job, one word per cycle.
  always_ff @(posedge clk_i) begin
    if (clear_we) begin
      mem[cnt_q] <= CLEAR_VALUE;
    end else if (user_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (write_strb_i[b]) mem[write_addr_i][8*b +: 8] <= write_data_i[8*b +: 8];
      end
    end
  end

  // Write-first forwarding merges only the strobed lanes over the stored word.
  always_comb begin
    rd_word = mem[read_addr_i];
    if (BYPASS && user_we && (write_addr_i == read_addr_i)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (write_strb_i[b]) rd_word[8*b +: 8] = write_data_i[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) s1_data <= rd_word;
    end
  end

  if (OUTPUT_REG == 0) begin : g_no_out_reg
    assign read_data_o  = s1_data;
    assign read_valid_o = s1_valid;
  end else begin : g_out_reg
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign read_data_o  = s2_data;
    assign read_valid_o = s2_valid;
  end

endmodule

// File: tb/tb_ram_sdp_clear.sv
// Directed bench for ram_sdp_clear: two instances share stimulus, one read-first with
// no output register and no reset clear, the other write-first, registered, reset-clear.
module tb_ram_sdp_clear;

  localparam int          DW    = 32;
  localparam int          AB    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] CV    = 32'h5A5A_5A5A;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          we;
  logic [AB-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [3:0]    strb;
  logic          re;
  logic [AB-1:0] raddr;

  logic          busy_a, busy_b;
  logic          rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_sdp_clear #(
    .DATA_WIDTH(DW), .ADDR_BITS(AB), .CLEAR_VALUE(CV),
    .CLEAR_ON_RESET(1'b0), .OUTPUT_REG(0), .BYPASS(1'b0)
  ) dut_a (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .busy_o(busy_a),
    .write_enable_i(we), .write_addr_i(waddr), .write_data_i(wdata), .write_strb_i(strb),
    .read_enable_i(re), .read_addr_i(raddr), .read_data_o(rdata_a), .read_valid_o(rvalid_a)
  );

  ram_sdp_clear #(
    .DATA_WIDTH(DW), .ADDR_BITS(AB), .CLEAR_VALUE(CV),
    .CLEAR_ON_RESET(1'b1), .OUTPUT_REG(1), .BYPASS(1'b1)
  ) dut_b (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .busy_o(busy_b),
    .write_enable_i(we), .write_addr_i(waddr), .write_data_i(wdata), .write_strb_i(strb),
    .read_enable_i(re), .read_addr_i(raddr), .read_data_o(rdata_b), .read_valid_o(rvalid_b)
  );

  typedef struct {
    logic          we;
    logic [AB-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [3:0]    strb;
    logic          re;
    logic [AB-1:0] raddr;
    logic          a_valid;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic [DW-1:0] b_data;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  logic [DW-1:0] exp_a [DEPTH];
  logic [DW-1:0] exp_b [DEPTH];

  function automatic vec_t mk(input logic w, input logic [AB-1:0] wa, input logic [DW-1:0] wd,
                              input logic [3:0] s, input logic r, input logic [AB-1:0] ra,
                              input logic av, input logic [DW-1:0] ad,
                              input logic bv, input logic [DW-1:0] bd);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.strb = s; v.re = r; v.raddr = ra;
    v.a_valid = av; v.a_data = ad; v.b_valid = bv; v.b_data = bd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    clear = 1'b0; we = 1'b0; waddr = '0; wdata = '0; strb = '0; re = 1'b0; raddr = '0;
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; waddr = AB'(i); wdata = base + DW'(i); strb = 4'hF;
      step();
    end
    drive_idle();
    step();
  endtask

  // Back-to-back reads of every address; a answers one edge later, b two.
  task automatic stream(input string tag);
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) begin re = 1'b1; raddr = AB'(i); end
      else re = 1'b0;
      step();
      if (i < DEPTH) begin
        check($sformatf("%s a valid %0d", tag, i), rvalid_a, 1'b1);
        check($sformatf("%s a data %0d", tag, i), rdata_a, exp_a[i]);
      end else begin
        check($sformatf("%s a valid end", tag), rvalid_a, 1'b0);
      end
      if (i >= 1) begin
        check($sformatf("%s b valid %0d", tag, i - 1), rvalid_b, 1'b1);
        check($sformatf("%s b data %0d", tag, i - 1), rdata_b, exp_b[i-1]);
      end else begin
        check($sformatf("%s b valid lead", tag), rvalid_b, 1'b0);
      end
    end
    step();
    check($sformatf("%s b valid end", tag), rvalid_b, 1'b0);
    check($sformatf("%s a data hold", tag), rdata_a, exp_a[DEPTH-1]);
    check($sformatf("%s b data hold", tag), rdata_b, exp_b[DEPTH-1]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            we    wa     wdata          strb  re    ra     a_v   a_data         b_v   b_data
    vecs[0]  = mk(1'b1, 4'd5,  32'hAABBCCDD, 4'hF, 1'b0, 4'd0,  1'b0, 32'h0,        1'b0, 32'h0);
    vecs[1]  = mk(1'b1, 4'd5,  32'h11223344, 4'h5, 1'b0, 4'd0,  1'b0, 32'h0,        1'b0, 32'h0);
    vecs[2]  = mk(1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd5,  1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44);
    vecs[3]  = mk(1'b1, 4'd3,  32'h0,        4'hF, 1'b1, 4'd5,  1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44);
    vecs[4]  = mk(1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 1'b1, 4'd3,  1'b1, 32'h0,        1'b1, 32'hDEADBEEF);
    vecs[5]  = mk(1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd3,  1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    vecs[6]  = mk(1'b1, 4'd7,  32'hFFFFFFFF, 4'h0, 1'b1, 4'd7,  1'b1, 32'h10000007, 1'b1, 32'h10000007);
    vecs[7]  = mk(1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd7,  1'b1, 32'h10000007, 1'b1, 32'h10000007);
    vecs[8]  = mk(1'b1, 4'd9,  32'h000000EE, 4'h1, 1'b1, 4'd9,  1'b1, 32'h10000009, 1'b1, 32'h100000EE);
    vecs[9]  = mk(1'b1, 4'd9,  32'hCAFE0000, 4'hC, 1'b1, 4'd8,  1'b1, 32'h10000008, 1'b1, 32'h10000008);
    vecs[10] = mk(1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd9,  1'b1, 32'hCAFE00EE, 1'b1, 32'hCAFE00EE);
    vecs[11] = mk(1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 4'd0,  1'b0, 32'h0,        1'b0, 32'h0);
    vecs[12] = mk(1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd0,  1'b1, 32'h10000000, 1'b1, 32'h10000000);
    vecs[13] = mk(1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd15, 1'b1, 32'h1000000F, 1'b1, 32'h1000000F);

    // Reset for three edges with a read request that must be ignored.
    drive_idle();
    reset = 1'b1; re = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      check($sformatf("reset a valid %0d", j), rvalid_a, 1'b0);
      check($sformatf("reset b valid %0d", j), rvalid_b, 1'b0);
      check($sformatf("reset a data %0d", j), rdata_a, 32'h0);
      check($sformatf("reset b data %0d", j), rdata_b, 32'h0);
      check($sformatf("reset a busy %0d", j), busy_a, 1'b0);
      check($sformatf("reset b busy %0d", j), busy_b, 1'b1);
    end
    reset = 1'b0; re = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      step();
      check($sformatf("reset clear b busy %0d", j), busy_b, (j < DEPTH - 1));
    end
    re = 1'b1; raddr = 4'd15;
    step();
    check("post reset a valid", rvalid_a, 1'b1);
    re = 1'b0;
    step();
    check("post reset b valid", rvalid_b, 1'b1);
    check("post reset b addr15", rdata_b, CV);
    check("post reset a single valid", rvalid_a, 1'b0);
    step();

    // Fill with a known pattern and stream it back in address order.
    fill(32'h1000_0000);
    for (int i = 0; i < DEPTH; i++) begin
      exp_a[i] = 32'h1000_0000 + i;
      exp_b[i] = 32'h1000_0000 + i;
    end
    stream("fill");

    // Table-driven strobe / read-during-write vectors; b lags a by one edge.
    for (int i = 0; i < NV; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata; strb = vecs[i].strb;
      re = vecs[i].re; raddr = vecs[i].raddr;
      step();
      check($sformatf("vec%0d a valid", i), rvalid_a, vecs[i].a_valid);
      if (vecs[i].a_valid) check($sformatf("vec%0d a data", i), rdata_a, vecs[i].a_data);
      if (i > 0) begin
        check($sformatf("vec%0d b valid", i - 1), rvalid_b, vecs[i-1].b_valid);
        if (vecs[i-1].b_valid) check($sformatf("vec%0d b data", i - 1), rdata_b, vecs[i-1].b_data);
      end
    end
    drive_idle();
    step();
    check($sformatf("vec%0d b valid", NV - 1), rvalid_b, vecs[NV-1].b_valid);
    check($sformatf("vec%0d b data", NV - 1), rdata_b, vecs[NV-1].b_data);
    step();

    // Clear request: busy for exactly DEPTH cycles, user traffic ignored meanwhile.
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      we = 1'b1; waddr = (j == 0) ? 4'd0 : AB'(j - 1); wdata = 32'hFFFF_FFFF; strb = 4'hF;
      re = 1'b1; raddr = AB'(j);
      check($sformatf("clear a busy %0d", j), busy_a, 1'b1);
      check($sformatf("clear b busy %0d", j), busy_b, 1'b1);
      check($sformatf("clear a valid %0d", j), rvalid_a, 1'b0);
      check($sformatf("clear b valid %0d", j), rvalid_b, 1'b0);
      check($sformatf("clear a hold %0d", j), rdata_a, 32'h1000000F);
      check($sformatf("clear b hold %0d", j), rdata_b, 32'h1000000F);
      step();
    end
    drive_idle();
    check("clear done a busy", busy_a, 1'b0);
    check("clear done b busy", busy_b, 1'b0);
    check("clear done a valid", rvalid_a, 1'b0);
    step();
    check("clear done b valid", rvalid_b, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_a[i] = CV;
      exp_b[i] = CV;
    end
    stream("clear");

    // Reset lands on the edge that would clear address 7.
    fill(32'h2000_0000);
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midclear a busy", busy_a, 1'b0);
    check("midclear b busy", busy_b, 1'b1);
    check("midclear a data", rdata_a, 32'h0);
    check("midclear b data", rdata_b, 32'h0);
    repeat (DEPTH - 1) step();
    check("midclear b busy late", busy_b, 1'b1);
    step();
    check("midclear b busy done", busy_b, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_a[i] = (i < 7) ? CV : 32'h2000_0000 + i;
      exp_b[i] = CV;
    end
    stream("midclear");

    // Reset with a read still in b's pipeline squashes its valid.
    re = 1'b1; raddr = 4'd0;
    step();
    check("inflight a valid", rvalid_a, 1'b1);
    check("inflight a data", rdata_a, CV);
    re = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("inflight b squashed", rvalid_b, 1'b0);
    check("inflight b data", rdata_b, 32'h0);
    check("inflight a data reset", rdata_a, 32'h0);
    step();
    check("inflight b no late valid", rvalid_b, 1'b0);
    repeat (DEPTH) step();
    check("final b busy", busy_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
